// File: rtl/multi_cycle_main_controller.sv
// Main sequencing FSM for the multi-cycle RV32I-subset CPU.
// Moore outputs decode from the state register; imm_src decodes from the opcode alone.
module multi_cycle_main_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic       func7_5,
  output logic       PC_write,
  output logic       PC_write_cond,
  output logic       adr_src,
  output logic       mem_write,
  output logic       IR_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] ALU_src_A,
  output logic [1:0] ALU_src_B,
  output logic [1:0] ALU_op,
  output logic [2:0] imm_src,
  output logic       halted
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNC   = 2'b10;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_JALR_ADR,
    S_JALR_PC,
    S_LUI,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_next;

  // The ALU decoder consumes func3/func7_5; sequencing never depends on them.
  logic w_unused_func;
  assign w_unused_func = ^{func3, func7_5};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RESET;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    PC_write      = 1'b0;
    PC_write_cond = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    IR_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = RES_ALUOUT;
    ALU_src_A     = SRCA_PC;
    ALU_src_B     = SRCB_REG;
    ALU_op        = ALU_ADD;
    halted        = 1'b0;

    case (r_state)
      S_RESET: begin
        w_next = S_FETCH;
      end

      S_FETCH: begin
        adr_src    = 1'b0;
        IR_write   = 1'b1;
        ALU_src_A  = SRCA_PC;
        ALU_src_B  = SRCB_FOUR;
        ALU_op     = ALU_ADD;
        result_src = RES_ALU;
        PC_write   = 1'b1;
        w_next     = S_DECODE;
      end

      // ALUOut captures old PC + imm here so branches and JAL have their target ready.
      S_DECODE: begin
        ALU_src_A = SRCA_OLDPC;
        ALU_src_B = SRCB_IMM;
        ALU_op    = ALU_ADD;
        case (op)
          OP_LW, OP_SW: w_next = S_MEM_ADR;
          OP_R:         w_next = S_EXEC_R;
          OP_I:         w_next = S_EXEC_I;
          OP_B:         w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          OP_JALR:      w_next = S_JALR_ADR;
          OP_LUI:       w_next = S_LUI;
          default:      w_next = S_HALT;
        endcase
      end

      S_MEM_ADR: begin
        ALU_src_A = SRCA_REG;
        ALU_src_B = SRCB_IMM;
        ALU_op    = ALU_ADD;
        w_next    = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end

      S_MEM_READ: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        w_next     = S_MEM_WB;
      end

      S_MEM_WB: begin
        result_src = RES_MDR;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end

      S_MEM_WRITE: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        w_next     = S_FETCH;
      end

      S_EXEC_R: begin
        ALU_src_A = SRCA_REG;
        ALU_src_B = SRCB_REG;
        ALU_op    = ALU_FUNC;
        w_next    = S_ALU_WB;
      end

      S_EXEC_I: begin
        ALU_src_A = SRCA_REG;
        ALU_src_B = SRCB_IMM;
        ALU_op    = ALU_FUNC;
        w_next    = S_ALU_WB;
      end

      S_ALU_WB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end

      // The branch-condition block qualifies the PC load; flags are never seen here.
      S_BRANCH: begin
        ALU_src_A     = SRCA_REG;
        ALU_src_B     = SRCB_REG;
        ALU_op        = ALU_SUB;
        result_src    = RES_ALUOUT;
        PC_write_cond = 1'b1;
        w_next        = S_FETCH;
      end

      S_JAL: begin
        ALU_src_A  = SRCA_OLDPC;
        ALU_src_B  = SRCB_FOUR;
        ALU_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        PC_write   = 1'b1;
        w_next     = S_ALU_WB;
      end

      S_JALR_ADR: begin
        ALU_src_A = SRCA_REG;
        ALU_src_B = SRCB_IMM;
        ALU_op    = ALU_ADD;
        w_next    = S_JALR_PC;
      end

      // PC loads rs1 + imm from ALUOut while the ALU forms the link value old PC + 4.
      S_JALR_PC: begin
        result_src = RES_ALUOUT;
        PC_write   = 1'b1;
        ALU_src_A  = SRCA_OLDPC;
        ALU_src_B  = SRCB_FOUR;
        ALU_op     = ALU_ADD;
        w_next     = S_ALU_WB;
      end

      S_LUI: begin
        result_src = RES_IMM;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end

      default: begin
        w_next = S_HALT;
      end
    endcase
  end

  always_comb begin
    imm_src = 3'b000;
    case (op)
      OP_I, OP_LW, OP_JALR: imm_src = 3'b000;
      OP_SW:                imm_src = 3'b001;
      OP_B:                 imm_src = 3'b010;
      OP_JAL:               imm_src = 3'b011;
      OP_LUI:               imm_src = 3'b100;
      default:              imm_src = 3'b000;
    endcase
  end

endmodule
